// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE handshake, relative branches via offset LUT.
// Optional taken-branch counter on output BranchCnt when FETCH_BRANCH_COUNT_EN is defined.
module fetch_unit #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned OFF_W     = 8,
    parameter int unsigned LUT_DEPTH = 16,
    localparam int unsigned IDX_W    = $clog2(LUT_DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Ack,
    input  logic             BranchTaken,
    input  logic             OffsetSrc,
    input  logic [IDX_W-1:0] LutIdx,
    input  logic [OFF_W-1:0] RegOffset,
    input  logic             LutWe,
    input  logic [IDX_W-1:0] LutWaddr,
    input  logic [OFF_W-1:0] LutWdata,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done
`ifdef FETCH_BRANCH_COUNT_EN
    ,
    output logic [15:0]      BranchCnt
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OFF_W-1:0] lut_q [LUT_DEPTH];
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  off_ext;

    // LUT read sees the pre-write value when a write hits the same entry this cycle.
    assign offset  = OffsetSrc ? RegOffset : lut_q[LutIdx];
    assign off_ext = {{(PC_W - OFF_W){offset[OFF_W-1]}}, offset};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            StIdle: begin
                pc_d = '0;
                if (Start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (Start) begin
                    pc_d = '0;
                end else if (Ack) begin
                    state_d = StDone;
                end else if (BranchTaken) begin
                    pc_d = pc_q + off_ext;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            StDone: begin
                if (Start) begin
                    pc_d    = '0;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (LutWe) begin
                lut_q[LutWaddr] <= LutWdata;
            end
        end
    end

    assign ProgCtr = pc_q;
    assign Running = (state_q == StRun);
    assign Done    = (state_q == StDone);

`ifdef FETCH_BRANCH_COUNT_EN
    logic [15:0] branch_cnt_q;

    // Start is accepted in every state, so it always clears the count.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            branch_cnt_q <= '0;
        end else if (Start) begin
            branch_cnt_q <= '0;
        end else if ((state_q == StRun) && BranchTaken && !Ack && (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_q <= branch_cnt_q + 16'd1;
        end
    end

    assign BranchCnt = branch_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch sequencer that feeds the instruction ROM address; the fetched 9-bit word goes to the control decoder.
- Consumes the decoder's Ack (halt) and OffsetSrc outputs, plus an externally resolved branch-taken flag.
- Computes the next PC as sequential, relative branch (offset from the 16-entry offset LUT or from a register), or hold.
- Owns the start/run/done handshake with the testbench/top level.

Parameters:
- PC_W, 10, program counter width; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 8, width of the signed branch offset (LUT entries and RegOffset).
- LUT_DEPTH, 16, number of offset LUT entries; index width is clog2(LUT_DEPTH).

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  level: (re)start program at PC 0.
- Ack  in  1  decoder halt indication for the current instruction.
- BranchTaken  in  1  current instruction is a branch and its condition holds.
- OffsetSrc  in  1  1 = offset from RegOffset, 0 = offset from LUT.
- LutIdx  in  clog2(LUT_DEPTH)  LUT index carried in the current instruction.
- RegOffset  in  OFF_W  signed offset read from the register file.
- LutWe  in  1  LUT write enable.
- LutWaddr  in  clog2(LUT_DEPTH)  LUT write address.
- LutWdata  in  OFF_W  LUT write data (signed).
- ProgCtr  out  PC_W  instruction ROM address.
- Running  out  1  high while in RUN.
- Done  out  1  high while in DONE.

Behaviour:
- Reset (Reset_n=0 at a clock edge), from any state, mid-program included:
  - state to IDLE, ProgCtr 0, Running 0, Done 0.
  - All LUT entries cleared to 0.
  - Reset has priority over every other input, including LutWe.
- States: IDLE, RUN, DONE. Running = (state==RUN); Done = (state==DONE); both are registered state decodes with no combinational path from inputs.
- IDLE:
  - Start=1 moves to RUN next cycle with ProgCtr 0.
  - Otherwise stay in IDLE with ProgCtr 0.
- RUN, priority high to low:
  - Start=1: ProgCtr 0, stay in RUN (restart).
  - Ack=1: go to DONE, ProgCtr holds. Ack overrides BranchTaken.
  - BranchTaken=1: ProgCtr <= ProgCtr + sext(offset), where offset = OffsetSrc ? RegOffset : LUT[LutIdx].
  - Otherwise: ProgCtr <= ProgCtr + 1.
- DONE:
  - ProgCtr holds; Ack and BranchTaken are ignored.
  - Start=1: ProgCtr 0, go to RUN next cycle.
- Arithmetic:
  - Offset is sign-extended from OFF_W to PC_W, added, and truncated to PC_W bits.
  - Wrap-around is silent in both directions: PC 2^PC_W-1 + 1 gives 0; PC 0 + (-1) gives 2^PC_W-1.
  - Branch offset 0 gives ProgCtr hold, i.e. a one-instruction self loop.
- Latency: ProgCtr is registered; the next-PC decision in cycle N uses the inputs of cycle N, and the new address is visible in cycle N+1. Zero-bubble: one instruction per cycle.
- LUT:
  - Read is combinational on LutIdx.
  - Write is synchronous when LutWe=1, allowed in any state.
  - Write and branch reading the same entry in the same cycle: the branch uses the old value; the new value is visible from the next cycle.
- Inputs are don't-care in IDLE and DONE except Start, LutWe, LutWaddr and LutWdata.

Optional Feature:
- Macro: FETCH_BRANCH_COUNT_EN.
- Defined:
  - Adds output port BranchCnt (16 bits).
  - Counts cycles in RUN where BranchTaken=1, Ack=0 and Start=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by every Start acceptance.
  - Holds in IDLE and DONE.
- Undefined: no BranchCnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then Start pulse, 5 cycles with no branch/Ack -> ProgCtr 0,1,2,3,4,5; Running=1, Done=0.
- In RUN at PC 20, LUT[3]=-4 (8'hFC), LutIdx=3, OffsetSrc=0, BranchTaken=1 -> PC 16 next cycle. Same again with OffsetSrc=1, RegOffset=8'h07 -> PC 23.
- At PC 1023 (PC_W=10) with no branch -> PC 0. At PC 0 with RegOffset=-1 taken -> PC 1023.
- At PC 40, Ack=1 and BranchTaken=1 in the same cycle -> DONE, PC stays 40, Done=1 thereafter; Start=1 -> PC 0 and Running=1 next cycle.
- LutWe writing LUT[5]=8'h10 in the same cycle as a taken branch with LutIdx=5 and old LUT[5]=2 at PC 100 -> PC 102. The next taken branch with LutIdx=5 from PC 102 -> PC 118.
- Reset_n=0 mid-RUN at PC 57 -> next cycle IDLE, PC 0, Done=0, LUT[3] reads 0. With FETCH_BRANCH_COUNT_EN defined, 3 taken branches -> BranchCnt=3, then Start -> BranchCnt=0.
